// File: rtl/lsu_handshake_unit.sv
// Load/store unit for the memory stage: request/response handshake to an
// external memory with variable latency, pipeline stall, byte-lane steering,
// load extension, misalignment detection and a bus timeout.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access outstanding; decode and accept new requests
// BUSY  | cs asserted, waiting for mem_valid or the timeout
// RESP  | one-cycle response; resp_valid high, pipeline released
module lsu_handshake_unit #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int EN_TIMEOUT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   load_data,
  output logic              misalign_exc,
  output logic              bus_fault,
  output logic              cs,
  output logic              mem_rd_wr,
  output logic [XLEN/8-1:0] mask,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_write_data,
  input  logic [XLEN-1:0]   mem_read_data,
  input  logic              mem_valid
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  // Only needs to reach TIMEOUT_CYC-1; one bit minimum for TIMEOUT_CYC == 1.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [2:0]        func3_q, func3_d;
  logic              rd_q, rd_d;
  logic [NB-1:0]     mask_q, mask_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   load_q, load_d;

  logic              legal;
  logic              aligned;
  logic              accept;
  logic              tmo_hit;
  logic [OFF_W-1:0]  req_off;
  logic [NB-1:0]     mask_n;
  logic [XLEN-1:0]   wdata_n;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   lifted;
  logic [7:0]        ext_sh;
  logic [XLEN-1:0]   load_fmt;

  assign req_off = req_addr[OFF_W-1:0];

  // Decode whether funct3 names a supported access for this XLEN, and alignment.
  always_comb begin
    legal = 1'b0;
    if (req_we) begin
      case (req_func3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b011:                 legal = (XLEN == 64);
        default:                legal = 1'b0;
      endcase
    end else begin
      case (req_func3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110:                         legal = (XLEN == 64);
        default:                                legal = 1'b0;
      endcase
    end
    case (req_func3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = (req_addr[2:0] == 3'b000);
    endcase
  end

  assign accept       = (state_q == ST_IDLE) & req_valid & legal & aligned;
  assign misalign_exc = (state_q == ST_IDLE) & req_valid & ~(legal & aligned);

  // Build the byte-lane mask and replicated store data for the incoming request.
  always_comb begin
    case (req_func3[1:0])
      2'b00: begin
        mask_n  = NB'(1) << req_off;
        wdata_n = {NB{req_wdata[7:0]}};
      end
      2'b01: begin
        mask_n  = NB'(3) << req_off;
        wdata_n = {(XLEN/16){req_wdata[15:0]}};
      end
      2'b10: begin
        mask_n  = NB'(15) << req_off;
        wdata_n = {(XLEN/32){req_wdata[31:0]}};
      end
      default: begin
        mask_n  = '1;
        wdata_n = req_wdata;
      end
    endcase
    if (!req_we) begin
      mask_n = '0;
    end
  end

  // Align the read data to bit 0 and extend it; the shift-up/shift-down pair
  // avoids zero-width replications when the access is already full width.
  always_comb begin
    shifted = mem_read_data >> {off_q, 3'b000};
    case (func3_q[1:0])
      2'b00:   ext_sh = 8'(XLEN - 8);
      2'b01:   ext_sh = 8'(XLEN - 16);
      2'b10:   ext_sh = 8'(XLEN - 32);
      default: ext_sh = 8'd0;
    endcase
    lifted = shifted << ext_sh;
    if (func3_q[2]) begin
      load_fmt = lifted >> ext_sh;
    end else begin
      load_fmt = $signed(lifted) >>> ext_sh;
    end
  end

  assign tmo_hit = (EN_TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Next-state, latch and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    off_d   = off_q;
    func3_d = func3_q;
    rd_d    = rd_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          addr_d  = {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
          off_d   = req_off;
          func3_d = req_func3;
          rd_d    = ~req_we;
          mask_d  = mask_n;
          wdata_d = wdata_n;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (mem_valid) begin
          state_d = ST_RESP;
          if (rd_q) begin
            load_d = load_fmt;
          end
        end else if (tmo_hit) begin
          state_d = ST_RESP;
          if (rd_q) begin
            load_d = '0;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      func3_q <= '0;
      rd_q    <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      func3_q <= func3_d;
      rd_q    <= rd_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
    end
  end

  assign stall          = accept | (state_q == ST_BUSY);
  assign cs             = (state_q == ST_BUSY);
  assign resp_valid     = (state_q == ST_RESP);
  assign bus_fault      = (state_q == ST_BUSY) & tmo_hit & ~mem_valid;
  assign load_data      = load_q;
  assign mem_rd_wr      = rd_q;
  assign mask           = mask_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;

endmodule
